// File: rtl/entity_pkg.sv
// Shared entity codes, default widths and game-state encoding for the sprite priority mux.
package entity_pkg;

    localparam int ID_W    = 7;
    localparam int COORD_W = 10;
    localparam int DIR_W   = 2;

    // Player (layer 0) overlapping layers 1..4 (the ghosts) ends the game by default
    localparam logic [31:0] DEFAULT_HIT_MASK = 32'h0000_001E;

    localparam logic [ID_W-1:0] NONE     = 7'd0;
    localparam logic [ID_W-1:0] PACMAN   = 7'd1;
    localparam logic [ID_W-1:0] MAZE     = 7'd2;
    localparam logic [ID_W-1:0] BLINKY   = 7'd3;
    localparam logic [ID_W-1:0] PINKY    = 7'd4;
    localparam logic [ID_W-1:0] INKY     = 7'd5;
    localparam logic [ID_W-1:0] CLYDE    = 7'd6;
    localparam logic [ID_W-1:0] PELLET   = 7'd7;
    localparam logic [ID_W-1:0] ONES     = 7'd8;
    localparam logic [ID_W-1:0] TENS     = 7'd9;
    localparam logic [ID_W-1:0] HUNDREDS = 7'd10;
    localparam logic [ID_W-1:0] THOUS    = 7'd11;
    localparam logic [ID_W-1:0] TENTHOUS = 7'd12;
    localparam logic [ID_W-1:0] CHERRY   = 7'd15;

    typedef enum logic {
        PLAYING = 1'b0,
        LOST    = 1'b1
    } game_state_t;

endpackage

// File: rtl/priority_enc.sv
// Lowest-index-first priority encoder: reports the smallest set request bit.
module priority_enc #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/entity_priority_mux.sv
// Sprite layer priority mux with player-collision bookkeeping and sticky game-over flag.
module entity_priority_mux #(
    parameter int                    N_LAYERS = 16,
    parameter int                    ID_W     = entity_pkg::ID_W,
    parameter int                    COORD_W  = entity_pkg::COORD_W,
    parameter int                    DIR_W    = entity_pkg::DIR_W,
    parameter logic [N_LAYERS-1:0]   HIT_MASK = entity_pkg::DEFAULT_HIT_MASK[N_LAYERS-1:0]
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [N_LAYERS-1:0]           is_layer,
    input  logic [N_LAYERS*ID_W-1:0]      layer_id,
    input  logic [N_LAYERS*DIR_W-1:0]     layer_dir,
    input  logic [N_LAYERS*COORD_W-1:0]   layer_x,
    input  logic [N_LAYERS*COORD_W-1:0]   layer_y,
    input  logic                          draw_en,
    input  logic                          frame_start,
    input  logic                          clear_lose,
    output logic [ID_W-1:0]               entity,
    output logic [DIR_W-1:0]              entityDir,
    output logic [COORD_W-1:0]            entityX,
    output logic [COORD_W-1:0]            entityY,
    output logic                          entity_valid,
    output logic [N_LAYERS-1:0]           collide_layers,
    output logic                          lose_game,
    output logic                          lose_pulse,
    output logic [7:0]                    last_frame_hits
);

    import entity_pkg::*;

    localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    // Layer 0 is the player itself, so it can never collide with itself
    localparam logic [N_LAYERS-1:0] HIT_USED = HIT_MASK & ~N_LAYERS'(1);

    logic [N_LAYERS-1:0] req;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    logic [N_LAYERS-1:0] hits;
    logic                coll_pix;
    logic [7:0]          hit_cnt;
    logic [7:0]          hit_cnt_inc;
    game_state_t         state_q;
    game_state_t         state_d;
    logic                lose_rise;

    assign req         = is_layer & {N_LAYERS{draw_en}};
    assign hits        = is_layer & HIT_USED;
    assign coll_pix    = draw_en & is_layer[0] & (|hits);
    assign hit_cnt_inc = (hit_cnt == 8'hFF) ? 8'hFF : hit_cnt + 8'd1;
    assign lose_game   = (state_q == LOST);

    priority_enc #(.N(N_LAYERS), .IDX_W(IDX_W)) u_enc (
        .req   (req),
        .index (win_idx),
        .found (win_found)
    );

    // Register the winning layer's fields, or all zeros when no layer is drawn
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            entity       <= '0;
            entityDir    <= '0;
            entityX      <= '0;
            entityY      <= '0;
            entity_valid <= 1'b0;
        end else if (win_found) begin
            entity       <= layer_id[win_idx*ID_W +: ID_W];
            entityDir    <= layer_dir[win_idx*DIR_W +: DIR_W];
            entityX      <= layer_x[win_idx*COORD_W +: COORD_W];
            entityY      <= layer_y[win_idx*COORD_W +: COORD_W];
            entity_valid <= 1'b1;
        end else begin
            entity       <= '0;
            entityDir    <= '0;
            entityX      <= '0;
            entityY      <= '0;
            entity_valid <= 1'b0;
        end
    end

    // Per-frame collision record and saturating pixel count; frame_start folds in the current pixel
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_cnt         <= 8'd0;
            last_frame_hits <= 8'd0;
            collide_layers  <= '0;
        end else if (frame_start) begin
            last_frame_hits <= coll_pix ? hit_cnt_inc : hit_cnt;
            hit_cnt         <= {7'd0, coll_pix};
            collide_layers  <= coll_pix ? hits : '0;
        end else if (coll_pix) begin
            hit_cnt         <= hit_cnt_inc;
            collide_layers  <= collide_layers | hits;
        end
    end

    // Game state register and the registered rising-edge pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= PLAYING;
            lose_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            lose_pulse <= lose_rise;
        end
    end

    // Collision sets LOST; clear_lose only returns to PLAYING when no collision is present
    always_comb begin
        state_d   = state_q;
        lose_rise = 1'b0;
        case (state_q)
            PLAYING: begin
                if (coll_pix) begin
                    state_d   = LOST;
                    lose_rise = 1'b1;
                end
            end
            LOST: begin
                if (clear_lose && !coll_pix) begin
                    state_d = PLAYING;
                end
            end
            default: state_d = PLAYING;
        endcase
    end

endmodule

// File: tb/tb_entity_priority_mux.sv
// Bench for entity_priority_mux: directed vectors, a behavioural model and per-cycle comparison.
module tb_entity_priority_mux;

    localparam int N  = 16;
    localparam int IW = 7;
    localparam int CW = 10;
    localparam int DW = 2;
    localparam logic [N-1:0] HMASK = 16'h001E;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b1;
    logic [N-1:0]      is_layer = '0;
    logic [N*IW-1:0]   layer_id = '0;
    logic [N*DW-1:0]   layer_dir = '0;
    logic [N*CW-1:0]   layer_x = '0;
    logic [N*CW-1:0]   layer_y = '0;
    logic              draw_en = 1'b0;
    logic              frame_start = 1'b0;
    logic              clear_lose = 1'b0;
    logic [IW-1:0]     entity;
    logic [DW-1:0]     entityDir;
    logic [CW-1:0]     entityX;
    logic [CW-1:0]     entityY;
    logic              entity_valid;
    logic [N-1:0]      collide_layers;
    logic              lose_game;
    logic              lose_pulse;
    logic [7:0]        last_frame_hits;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    // Per-layer data as the game would see it
    logic [IW-1:0] ids[N];
    logic [DW-1:0] dirs[N];
    logic [CW-1:0] xs[N];
    logic [CW-1:0] ys[N];

    // Model state
    int  m_entity, m_dir, m_x, m_y, m_valid;
    int  m_collide, m_lose, m_pulse, m_last, m_count;
    int  win;
    int  hitset;
    bit  coll;

    entity_priority_mux dut (
        .Clk(Clk), .Reset_n(Reset_n), .is_layer(is_layer), .layer_id(layer_id),
        .layer_dir(layer_dir), .layer_x(layer_x), .layer_y(layer_y), .draw_en(draw_en),
        .frame_start(frame_start), .clear_lose(clear_lose), .entity(entity),
        .entityDir(entityDir), .entityX(entityX), .entityY(entityY),
        .entity_valid(entity_valid), .collide_layers(collide_layers), .lose_game(lose_game),
        .lose_pulse(lose_pulse), .last_frame_hits(last_frame_hits)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic loadLayers();
        for (int k = 0; k < N; k++) begin
            ids[k]  = IW'(k + 1);
            dirs[k] = DW'(k % 4);
            xs[k]   = CW'(100 + 10 * k);
            ys[k]   = CW'(50 + 7 * k);
        end
        ids[1] = 7'd3;
        ids[2] = 7'd4;
        for (int k = 0; k < N; k++) begin
            layer_id[k*IW +: IW]  = ids[k];
            layer_dir[k*DW +: DW] = dirs[k];
            layer_x[k*CW +: CW]   = xs[k];
            layer_y[k*CW +: CW]   = ys[k];
        end
    endtask

    // Drive one pixel's worth of inputs; returns just after the edge that consumed them
    task automatic applyStimulus(input logic [N-1:0] layers, input logic de,
                                 input logic fs, input logic cl);
        @(negedge Clk);
        #1;
        is_layer    = layers;
        draw_en     = de;
        frame_start = fs;
        clear_lose  = cl;
        @(posedge Clk);
        #1;
    endtask

    // Behavioural model: first drawn layer wins; collisions are counted and recorded per frame
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_entity = 0; m_dir = 0; m_x = 0; m_y = 0; m_valid = 0;
            m_collide = 0; m_lose = 0; m_pulse = 0; m_last = 0; m_count = 0;
        end else begin
            win = -1;
            for (int k = 0; k < N; k++)
                if (draw_en && is_layer[k] && win < 0) win = k;
            if (win >= 0) begin
                m_entity = ids[win]; m_dir = dirs[win]; m_x = xs[win]; m_y = ys[win]; m_valid = 1;
            end else begin
                m_entity = 0; m_dir = 0; m_x = 0; m_y = 0; m_valid = 0;
            end
            hitset = 0;
            for (int k = 1; k < N; k++)
                if (is_layer[k] && HMASK[k]) hitset = hitset + (1 << k);
            coll = draw_en && is_layer[0] && (hitset != 0);
            if (frame_start) begin
                m_last    = (m_count + int'(coll) > 255) ? 255 : m_count + int'(coll);
                m_count   = int'(coll);
                m_collide = coll ? hitset : 0;
            end else if (coll) begin
                m_count   = (m_count >= 255) ? 255 : m_count + 1;
                m_collide = m_collide | hitset;
            end
            m_pulse = (coll && m_lose == 0) ? 1 : 0;
            if (coll) m_lose = 1;
            else if (clear_lose) m_lose = 0;
        end
    end

    // Every cycle, compare all outputs against the model
    always @(negedge Clk) begin
        if (chk_en) begin
            checkOutput("cmp_entity", 32'(entity), 32'(m_entity));
            checkOutput("cmp_dir", 32'(entityDir), 32'(m_dir));
            checkOutput("cmp_x", 32'(entityX), 32'(m_x));
            checkOutput("cmp_y", 32'(entityY), 32'(m_y));
            checkOutput("cmp_valid", 32'(entity_valid), 32'(m_valid));
            checkOutput("cmp_collide", 32'(collide_layers), 32'(m_collide));
            checkOutput("cmp_lose", 32'(lose_game), 32'(m_lose));
            checkOutput("cmp_pulse", 32'(lose_pulse), 32'(m_pulse));
            checkOutput("cmp_last", 32'(last_frame_hits), 32'(m_last));
        end
    end

    initial begin
        loadLayers();
        #2 Reset_n = 1'b0;
        #1 chk_en = 1'b1;
        @(posedge Clk); #1;
        checkOutput("reset_entity", 32'(entity), 32'd0);
        checkOutput("reset_lose", 32'(lose_game), 32'd0);
        @(negedge Clk); #1;
        Reset_n = 1'b1;

        // Layers 1 and 2 both hit: layer 1 wins
        applyStimulus(16'h0006, 1'b1, 1'b0, 1'b0);
        checkOutput("sel_entity", 32'(entity), 32'd3);
        checkOutput("sel_valid", 32'(entity_valid), 32'd1);
        checkOutput("sel_x", 32'(entityX), 32'd110);
        checkOutput("sel_y", 32'(entityY), 32'd57);

        // Blanking region: nothing selected
        applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b0);
        checkOutput("blank_valid", 32'(entity_valid), 32'd0);
        checkOutput("blank_entity", 32'(entity), 32'd0);

        // Player overlapping a non-hit layer
        applyStimulus(16'h0021, 1'b1, 1'b0, 1'b0);
        checkOutput("nohit_entity", 32'(entity), 32'd1);
        checkOutput("nohit_lose", 32'(lose_game), 32'd0);
        checkOutput("nohit_collide", 32'(collide_layers), 32'd0);

        // Lowest-priority layer alone
        applyStimulus(16'h8000, 1'b1, 1'b0, 1'b0);
        checkOutput("top_entity", 32'(entity), 32'd16);
        checkOutput("top_x", 32'(entityX), 32'd250);

        // Three collision pixels with layer 1
        applyStimulus(16'h0003, 1'b1, 1'b0, 1'b0);
        checkOutput("coll1_lose", 32'(lose_game), 32'd1);
        checkOutput("coll1_pulse", 32'(lose_pulse), 32'd1);
        checkOutput("coll1_collide", 32'(collide_layers), 32'h0002);
        applyStimulus(16'h0003, 1'b1, 1'b0, 1'b0);
        checkOutput("coll2_pulse", 32'(lose_pulse), 32'd0);
        applyStimulus(16'h0003, 1'b1, 1'b0, 1'b0);
        checkOutput("coll3_lose", 32'(lose_game), 32'd1);
        checkOutput("coll3_pulse", 32'(lose_pulse), 32'd0);

        // Frame boundary without collision
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0);
        checkOutput("frame1_last", 32'(last_frame_hits), 32'd3);
        checkOutput("frame1_collide", 32'(collide_layers), 32'd0);

        // clear_lose against a collision, then alone, then a fresh collision
        applyStimulus(16'h0005, 1'b1, 1'b0, 1'b1);
        checkOutput("clrcoll_lose", 32'(lose_game), 32'd1);
        checkOutput("clrcoll_pulse", 32'(lose_pulse), 32'd0);
        checkOutput("clrcoll_collide", 32'(collide_layers), 32'h0004);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_lose", 32'(lose_game), 32'd0);
        applyStimulus(16'h0009, 1'b1, 1'b0, 1'b0);
        checkOutput("rearm_pulse", 32'(lose_pulse), 32'd1);
        checkOutput("rearm_collide", 32'(collide_layers), 32'h000C);

        // Saturation of the per-frame count
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0);
        checkOutput("frame2_last", 32'(last_frame_hits), 32'd2);
        for (int i = 0; i < 300; i++) applyStimulus(16'h0003, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0);
        checkOutput("sat_last", 32'(last_frame_hits), 32'd255);
        applyStimulus(16'h0011, 1'b1, 1'b1, 1'b0);
        checkOutput("restart_last", 32'(last_frame_hits), 32'd1);
        checkOutput("restart_collide", 32'(collide_layers), 32'h0010);
        for (int i = 0; i < 10; i++) applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0);
        checkOutput("frame4_last", 32'(last_frame_hits), 32'd1);

        // Asynchronous reset mid-frame while lost
        applyStimulus(16'h0006, 1'b1, 1'b0, 1'b0);
        checkOutput("prerst_entity", 32'(entity), 32'd3);
        checkOutput("prerst_lose", 32'(lose_game), 32'd1);
        #1 Reset_n = 1'b0;
        #1;
        checkOutput("async_entity", 32'(entity), 32'd0);
        checkOutput("async_valid", 32'(entity_valid), 32'd0);
        checkOutput("async_lose", 32'(lose_game), 32'd0);
        checkOutput("async_last", 32'(last_frame_hits), 32'd0);
        checkOutput("async_x", 32'(entityX), 32'd0);
        @(negedge Clk); #1;
        Reset_n = 1'b1;

        // Accumulation after reset release with no frame_start
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'h0003, 1'b1, 1'b0, 1'b0);
            if (i == 0) checkOutput("postrst_pulse", 32'(lose_pulse), 32'd1);
        end
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0);
        checkOutput("postrst_last", 32'(last_frame_hits), 32'd5);

        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/entity_priority_mux.md
ENTITY_PRIORITY_MUX -- requirements
Module: entity_priority_mux

Interface
REQ-001 Parameter N_LAYERS, default 16: number of sprite layers; index 0 has the highest priority; legal range 2..32.
REQ-002 Parameter ID_W, default 7: entity code width.
REQ-003 Parameter COORD_W, default 10: coordinate width.
REQ-004 Parameter DIR_W, default 2: direction width.
REQ-005 Parameter HIT_MASK, default 'h001E, N_LAYERS bits: layers whose overlap with layer 0 (player) counts as a collision; bit 0 ignored.
REQ-006 Clk  in  1  system clock; the block is single-clock.
REQ-007 Reset_n  in  1  asynchronous, active-low reset.
REQ-008 is_layer  in  N_LAYERS  per-layer pixel hit for the current DrawX/DrawY.
REQ-009 layer_id  in  N_LAYERS*ID_W  per-layer entity code, packed, layer k at [k*ID_W +: ID_W].
REQ-010 layer_dir  in  N_LAYERS*DIR_W  per-layer direction, packed likewise.
REQ-011 layer_x, layer_y  in  N_LAYERS*COORD_W each  per-layer sprite origin, packed likewise.
REQ-012 draw_en  in  1  high during the visible region; low means inputs are don't-care.
REQ-013 frame_start  in  1  one-cycle pulse at the first pixel of each frame.
REQ-014 clear_lose  in  1  synchronous clear of the sticky lose state.
REQ-015 entity  out  ID_W  selected entity code, registered.
REQ-016 entityDir, entityX, entityY  out  DIR_W/COORD_W/COORD_W  fields of the selected layer, registered.
REQ-017 entity_valid  out  1  some layer hit on the corresponding pixel.
REQ-018 collide_layers  out  N_LAYERS  per-frame sticky record of layers that collided with layer 0.
REQ-019 lose_game  out  1  sticky game-over flag.
REQ-020 lose_pulse  out  1  one-cycle pulse when lose_game rises.
REQ-021 last_frame_hits  out  8  collision-pixel count of the previous frame.

Function
REQ-022 Selection: the winner is the lowest index k with is_layer[k]=1 and draw_en=1; all outputs are registered with exactly 1 cycle of latency.
REQ-023 No winner: entity, entityDir, entityX, entityY and entity_valid are 0 on the next cycle.
REQ-024 Collision pixel: draw_en & is_layer[0] & |(is_layer & HIT_MASK & ~1).
REQ-025 collide_layers: ORs in (is_layer & HIT_MASK & ~1) on each collision pixel; bit 0 stays 0.
REQ-026 Per-frame counter: an 8-bit count increments on each collision pixel and saturates at 255.
REQ-027 frame_start: last_frame_hits <= counter including the current cycle (saturated); counter restarts at the current cycle's contribution (0 or 1); collide_layers <= current cycle's hits only.
REQ-028 lose_game: set on the cycle after the first collision pixel; holds until clear_lose or reset.
REQ-029 clear_lose and a collision in the same cycle: set wins, and lose_game stays 1.
REQ-030 lose_pulse: high exactly one cycle, coincident with the 0->1 transition of lose_game; no re-pulse while lose_game stays high.
REQ-031 Internal state: two states, PLAYING and LOST, held as the lose_game register; frame bookkeeping continues in both states.

Reset
REQ-032 Reset_n low asynchronously forces all outputs, the counter and all state to 0 (PLAYING).
REQ-033 Reset released mid-frame: accumulation starts from 0 with no frame_start required.

Structure
REQ-034 Package entity_pkg holds: entity code constants (NONE=0, PACMAN=1, MAZE=2, BLINKY=3, PINKY=4, INKY=5, CLYDE=6, PELLET=7, ONES..TENTHOUS=8..12, CHERRY=15), ID_W, COORD_W, DIR_W, and the default HIT_MASK.
REQ-035 Sub-module: priority_enc (N-bit lowest-index-first encoder, outputs index and found).

Verification
REQ-036 is_layer=16'h0006 with layer 1 id=3 and layer 2 id=4 -> one cycle later entity=3, entity_valid=1, entityX/entityY equal layer 1's values.
REQ-037 is_layer=16'h0003 for 3 cycles -> lose_game=1 from cycle+1, lose_pulse high exactly 1 cycle, collide_layers=16'h0002.
REQ-038 is_layer=16'h0021 (bit 5 not in HIT_MASK) -> no collision, lose_game stays 0.
REQ-039 300 collision pixels, then frame_start -> last_frame_hits=255 and the counter restarts.
REQ-040 clear_lose asserted together with a collision pixel -> lose_game stays 1; clear_lose alone -> 0 next cycle.
REQ-041 Reset_n pulsed low mid-frame while lose_game=1 -> all outputs 0 immediately, before the next Clk edge.
